// File: rtl/counter_ctrl_conditioner.sv
// ---------------------------------------------------------------------------
// counter_ctrl_conditioner
//
// Conditions three raw, bouncy push-buttons into clean control signals for
// an 8-bit up/down/load counter. Each channel runs through a 2-flop
// synchroniser, an integrating debouncer and a rising-edge one-shot.
//
// Ports:
//   clk        in   single clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   ena        in   0 freezes debounce/direction/repeat state, kills pulses
//   btn_step   in   raw step button (asynchronous)
//   btn_dir    in   raw direction-toggle button (asynchronous)
//   btn_load   in   raw load button (asynchronous)
//   count_en   out  one-cycle step pulse
//   count_up   out  direction level, 1 = up (reset value 1)
//   do_load    out  one-cycle load pulse (wins over a same-cycle step)
//   btn_state  out  debounced levels {load, dir, step}
//
// Optional feature macro: AUTO_REPEAT_EN
//   Defined: holding step emits extra count_en pulses REPEAT_DELAY cycles
//   after the first pulse, then every REPEAT_PERIOD cycles.
//   Undefined: no repeat timer is built; REPEAT_* parameters are ignored.
// ---------------------------------------------------------------------------
module counter_ctrl_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       btn_step,
    input  logic       btn_dir,
    input  logic       btn_load,
    output logic       count_en,
    output logic       count_up,
    output logic       do_load,
    output logic [2:0] btn_state
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Channel order everywhere: bit 2 = load, bit 1 = dir, bit 0 = step
    logic [2:0]         raw_s;
    logic [2:0]         sync1_q;
    logic [2:0]         sync2_q;
    logic [2:0][CW-1:0] db_cnt_q;
    logic [2:0][CW-1:0] db_cnt_d;
    logic [2:0]         deb_q;
    logic [2:0]         deb_d;
    logic [2:0]         deb_prev_q;
    logic [2:0]         rise_s;
    logic               step_fire_s;
    logic               rpt_fire_s;
    logic               count_en_q;
    logic               count_en_d;
    logic               count_up_q;
    logic               count_up_d;
    logic               do_load_q;
    logic               do_load_d;

    assign raw_s  = {btn_load, btn_dir, btn_step};
    assign rise_s = deb_q & ~deb_prev_q;

    // Debouncer next state: integrate disagreement, flip after DEBOUNCE_CYCLES
    always_comb begin
        db_cnt_d = db_cnt_q;
        deb_d    = deb_q;
        for (int i = 0; i < 3; i++) begin
            if (!ena) begin
                db_cnt_d[i] = db_cnt_q[i];
                deb_d[i]    = deb_q[i];
            end else if (sync2_q[i] == deb_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                deb_d[i]    = ~deb_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Pulse / direction next state; a load rise suppresses any step pulse
    always_comb begin
        step_fire_s = ena & rise_s[0] & ~rise_s[2];
        count_en_d  = step_fire_s | rpt_fire_s;
        do_load_d   = ena & rise_s[2];
        if (ena && rise_s[1]) begin
            count_up_d = ~count_up_q;
        end else begin
            count_up_d = count_up_q;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int             RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int             RW        = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0]  RPT_DLY   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0]  RPT_PER   = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0]  RPT_ONE   = RW'(1);

    logic [RW-1:0] rpt_cnt_q;
    logic [RW-1:0] rpt_cnt_d;
    logic          rpt_run_q;
    logic          rpt_run_d;
    logic          rpt_first_q;
    logic          rpt_first_d;
    logic [RW-1:0] rpt_limit_s;

    // Repeat timer: counts cycles since the last step pulse while step is held
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_run_d   = rpt_run_q;
        rpt_first_d = rpt_first_q;
        rpt_fire_s  = 1'b0;
        rpt_limit_s = rpt_first_q ? RPT_DLY : RPT_PER;
        if (!ena) begin
            rpt_cnt_d = rpt_cnt_q;
        end else if (!deb_q[0] || rise_s[2]) begin
            rpt_cnt_d   = '0;
            rpt_run_d   = 1'b0;
            rpt_first_d = 1'b0;
        end else if (step_fire_s) begin
            // the cycle of the first pulse counts as 1
            rpt_cnt_d   = RPT_ONE;
            rpt_run_d   = 1'b1;
            rpt_first_d = 1'b1;
        end else if (rpt_run_q) begin
            if (rpt_cnt_q == rpt_limit_s) begin
                rpt_fire_s  = 1'b1;
                rpt_cnt_d   = RPT_ONE;
                rpt_first_d = 1'b0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_ONE;
            end
        end else begin
            rpt_cnt_d = rpt_cnt_q;
        end
    end

    // Repeat timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_run_q   <= 1'b0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_run_q   <= rpt_run_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    assign rpt_fire_s = 1'b0;
`endif

    // Main state registers; sync and edge flops run regardless of ena so
    // nothing seen while disabled is replayed as a pulse afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            db_cnt_q   <= '0;
            deb_q      <= 3'b000;
            deb_prev_q <= 3'b000;
            count_en_q <= 1'b0;
            count_up_q <= 1'b1;
            do_load_q  <= 1'b0;
        end else begin
            sync1_q    <= raw_s;
            sync2_q    <= sync1_q;
            db_cnt_q   <= db_cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            count_en_q <= count_en_d;
            count_up_q <= count_up_d;
            do_load_q  <= do_load_d;
        end
    end

    assign count_en  = count_en_q;
    assign count_up  = count_up_q;
    assign do_load   = do_load_q;
    assign btn_state = deb_q;

endmodule

// File: tb/tb_counter_ctrl_conditioner.sv
// Directed, table-driven bench for counter_ctrl_conditioner with
// DEBOUNCE_CYCLES=4 (flip after edge 6, pulse after edge 7 of a press).
module tb_counter_ctrl_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       btn_step = 1'b0;
    logic       btn_dir = 1'b0;
    logic       btn_load = 1'b0;
    logic       count_en;
    logic       count_up;
    logic       do_load;
    logic [2:0] btn_state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       s;
        logic       d;
        logic       l;
        logic       e;
        logic       exp_en;
        logic       exp_up;
        logic       exp_ld;
        logic [2:0] exp_st;
    } vec_t;

    vec_t vecs[$];

    counter_ctrl_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .btn_step (btn_step),
        .btn_dir  (btn_dir),
        .btn_load (btn_load),
        .count_en (count_en),
        .count_up (count_up),
        .do_load  (do_load),
        .btn_state(btn_state)
    );

    always #5 clk = ~clk;

    task automatic add(input int n, input logic s, input logic d, input logic l, input logic e,
                       input logic en, input logic up, input logic ld, input logic [2:0] st);
        vec_t v;
        v.s = s; v.d = d; v.l = l; v.e = e;
        v.exp_en = en; v.exp_up = up; v.exp_ld = ld; v.exp_st = st;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic en, input logic up,
                             input logic ld, input logic [2:0] st);
        check({tag, ".count_en"},  idx, {2'b00, count_en}, {2'b00, en});
        check({tag, ".count_up"},  idx, {2'b00, count_up}, {2'b00, up});
        check({tag, ".do_load"},   idx, {2'b00, do_load},  {2'b00, ld});
        check({tag, ".btn_state"}, idx, btn_state, st);
    endtask

`ifdef AUTO_REPEAT_EN
    function automatic logic rpt_expect(input int k);
        return (k == 7) || (k == 17) || (k == 22) || (k == 27) || (k == 32) || (k == 37) || (k == 42);
    endfunction
`endif

    initial begin
        // ---- vector table: inputs for one edge, outputs expected after it
        // clean step press
        add(5, 1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b000);
        add(1, 1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b001);
        add(1, 1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0, 3'b001);
        add(3, 1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b001);
        add(5, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b001);
        add(1, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b000);
        // direction press: up -> down, release has no effect
        add(5, 1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b000);
        add(1, 1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b010);
        add(2, 1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0, 3'b010);
        add(5, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 3'b010);
        add(1, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 3'b000);
        // second direction press: down -> up
        add(5, 1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0, 3'b000);
        add(1, 1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0, 3'b010);
        add(1, 1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b010);
        add(5, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b010);
        add(1, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b000);
        // step and load together: load wins
        add(5, 1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0, 3'b000);
        add(1, 1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0, 3'b101);
        add(1, 1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b1, 3'b101);
        add(1, 1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0, 3'b101);
        add(5, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b101);
        add(1, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b000);
        // bounce 1,0,1,1,0 then stable high from the 6th sample
        add(1, 1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b000);
        add(1, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b000);
        add(2, 1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b000);
        add(1, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b000);
        add(5, 1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b000);
        add(1, 1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b001);
        add(1, 1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0, 3'b001);
        add(3, 1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b001);
        add(5, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b001);
        add(1, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b000);
        // step and dir together: step pulse arrives with the new direction
        add(5, 1'b1,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b000);
        add(1, 1'b1,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0, 3'b011);
        add(1, 1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0, 3'b011);
        add(1, 1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0, 3'b011);
        add(5, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 3'b011);
        add(1, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 3'b000);

        // ---- initial reset
        repeat (3) @(posedge clk);
        #1;
        check_all("rst0", 0, 1'b0, 1'b1, 1'b0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- apply table
        foreach (vecs[i]) begin
            btn_step = vecs[i].s;
            btn_dir  = vecs[i].d;
            btn_load = vecs[i].l;
            ena      = vecs[i].e;
            @(posedge clk);
            #1;
            check_all("vec", i + 1, vecs[i].exp_en, vecs[i].exp_up, vecs[i].exp_ld, vecs[i].exp_st);
        end

        // ---- ena gating: two counts of progress, freeze 30 cycles, resume
        btn_load = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check_all("ena_pre", k, 1'b0, 1'b0, 1'b0, 3'b000);
        end
        ena = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            check_all("ena_off", k, 1'b0, 1'b0, 1'b0, 3'b000);
        end
        ena = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check_all("ena_on", k, 1'b0, 1'b0, (k == 3), (k >= 2) ? 3'b100 : 3'b000);
        end

        // ---- async reset mid-press, no clock edge needed
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst_async", 0, 1'b0, 1'b1, 1'b0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        // held load is debounced afresh and pulses once
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            check_all("rst_press", k, 1'b0, 1'b1, (k == 7), (k >= 6) ? 3'b100 : 3'b000);
        end
        btn_load = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_all("rst_rel", 0, 1'b0, 1'b1, 1'b0, 3'b000);

`ifdef AUTO_REPEAT_EN
        // ---- auto-repeat: hold step 40 edges, then release
        for (int k = 1; k <= 55; k++) begin
            btn_step = (k <= 40);
            @(posedge clk); #1;
            check("rpt.count_en", k, {2'b00, count_en}, {2'b00, rpt_expect(k)});
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_ctrl_conditioner.md
Name: counter_ctrl_conditioner

Overview:
Front-end conditioning stage that sits directly upstream of the 8-bit up/down/load counter. It turns three raw, bouncy push-button inputs into the counter's clean control signals:
- count_en: one-cycle step pulse
- count_up: direction level, toggled by a button
- do_load: one-cycle load pulse

Each channel has a 2-flop synchroniser, an integrating debouncer and a rising-edge one-shot.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised input must differ from its debounced state before that state flips; legal range 2..65535.
REPEAT_DELAY, 1000, cycles from first step pulse to first auto-repeat pulse (used only with AUTO_REPEAT_EN).
REPEAT_PERIOD, 250, cycles between subsequent auto-repeat pulses (used only with AUTO_REPEAT_EN).

Ports:
clk  input  1  single clock; all state on rising edge.
rst_n  input  1  asynchronous, active-low reset.
ena  input  1  design enable; 0 freezes debounce counters and suppresses pulses.
btn_step  input  1  raw step button, asynchronous.
btn_dir  input  1  raw direction-toggle button, asynchronous.
btn_load  input  1  raw load button, asynchronous.
count_en  output  1  one-cycle step pulse to the counter.
count_up  output  1  direction level: 1 = up, 0 = down.
do_load  output  1  one-cycle load pulse to the counter.
btn_state  output  3  debounced levels {load, dir, step}, for status display.

Behaviour:
- Reset (rst_n=0, async): all of the following clear immediately:
  - sync flops, debounce counters, debounced states, edge registers, repeat timer
  - count_en=0, do_load=0, btn_state=3'b000
  - count_up is set to 1 (up)
- Reset mid-press: all state clears. After release of reset, a still-held button is debounced afresh and yields exactly one pulse.
- Synchroniser: 2 flops per channel. These flops run regardless of ena.
- Debouncer, per channel:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If sync value equals the debounced state, the counter clears to 0.
  - If it differs, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced state flips and the counter clears on that edge.
  - Any single-cycle return to the old value restarts the count from 0.
- Edge / pulse generation:
  - A rising edge of a debounced state is registered into a one-cycle pulse on the following edge.
  - Total latency: raw high sampled at edge 1 → pulse high after edge DEBOUNCE_CYCLES+3, lasting exactly one cycle.
  - Falling edges produce no pulse.
  - A button held indefinitely produces exactly one pulse, unless AUTO_REPEAT_EN is defined.
- Direction: a debounced rising edge of btn_dir toggles count_up, with the same latency as a pulse. Releasing btn_dir has no effect.
- Simultaneous events:
  - If step and load pulses would fire in the same cycle, do_load=1 and count_en is suppressed for that cycle (load wins).
  - A direction toggle in the same cycle as a step pulse takes effect together with it, so the counter steps in the new direction.
- ena=0:
  - Debounce counters, debounced states, count_up and the repeat timer hold their values.
  - count_en and do_load are forced to 0.
  - On return to ena=1, operation resumes from the held state; no pulses are queued while disabled.
- btn_state: equals the registered debounced states, with the same latency as the debounced flip.

Optional Feature:
Macro AUTO_REPEAT_EN.
- Defined:
  - While the debounced step state stays high, a repeat timer starts at the first count_en pulse.
  - An extra count_en pulse is emitted REPEAT_DELAY cycles after the first pulse, then every REPEAT_PERIOD cycles.
  - Releasing the button (debounced low) clears the timer immediately.
  - A load pulse clears the timer and suppresses that cycle's repeat.
  - With ena=0 the timer holds its value.
- Not defined: no timer logic is built; each press gives exactly one count_en pulse; REPEAT_DELAY and REPEAT_PERIOD are ignored.

Test Plan:
1. Reset value check, DEBOUNCE_CYCLES=4: assert rst_n=0 mid-run → count_up=1, count_en=0, do_load=0, btn_state=000, all immediately with no clock edge.
2. Clean step press, DEBOUNCE_CYCLES=4: btn_step rises and is sampled at edge 1, held 20 cycles → count_en high for exactly 1 cycle after edge 7; btn_state[0]=1 after edge 6; no further pulses.
3. Bounce rejection, DEBOUNCE_CYCLES=4: btn_step toggles 1,0,1,1,0,1 on successive cycles, then holds high → exactly one pulse, 7 edges after the final stable rise; glitches shorter than 4 cycles produce nothing.
4. Direction plus simultaneous events: press btn_dir → count_up 1→0; press btn_dir again → back to 1; btn_step and btn_load rise on the same edge → do_load=1 and count_en=0 in the same cycle.
5. ena gating: hold btn_load with ena=0 for 30 cycles → do_load stays 0 and the counter holds; raise ena → debouncing continues from the held count and exactly one do_load pulse follows.
6. AUTO_REPEAT_EN defined, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5: hold btn_step 40 cycles → pulses at edges 7, 17, 22, 27, 32, …; release → pulses stop within DEBOUNCE_CYCLES+2 cycles.
